// File: rtl/mem_arbiter_ctrl.sv
// Shares one 32-bit memory port between instruction fetch and load/store.
// Define MEM_ARB_TIMEOUT_EN for the bus-ack timeout and the bus_err output.
module mem_arbiter_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_size,
    input  logic              data_unsigned,
    input  logic [31:0]       data_wdata,
    output logic              data_done,
    output logic [31:0]       data_rdata,
    output logic              data_misalign,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic              bus_err,
`endif
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic              own_if, own_if_nx;
    logic              prio_data, prio_data_nx;
    logic [1:0]        lat_size, lat_size_nx;
    logic [1:0]        lat_off, lat_off_nx;
    logic              lat_uns, lat_uns_nx;
    logic              mem_req_nx, mem_we_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [31:0]       mem_wdata_nx;
    logic [3:0]        mem_wmask_nx;
    logic              if_done_nx, data_done_nx, data_misalign_nx;
    logic [31:0]       if_rdata_nx, data_rdata_nx;

    logic              gnt_data, gnt_if, data_mis;
    logic [3:0]        st_mask;
    logic [31:0]       st_wdata, ld_shift, ld_data;
    logic              unused_if_lsb;

    // fetch addresses are word aligned, so their low bits carry nothing
    assign unused_if_lsb = ^if_addr[1:0];

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit, bus_err_nx;

    assign tmo_hit = (state == BUSY) && !mem_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state != BUSY) tmo_cnt <= '0;
        else                      tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

    // priority pointer only matters when both requesters collide
    assign gnt_data = data_req & (~if_req | prio_data);
    assign gnt_if   = if_req & ~gnt_data;

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = data_req & ~data_done;

    always_comb begin
        data_mis = 1'b0;
        st_mask  = 4'b0000;
        st_wdata = data_wdata;
        case (data_size)
            SZ_B: begin
                st_mask  = 4'b0001 << data_addr[1:0];
                st_wdata = {4{data_wdata[7:0]}};
            end
            SZ_H: begin
                data_mis = data_addr[0];
                st_mask  = data_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{data_wdata[15:0]}};
            end
            SZ_W: begin
                data_mis = |data_addr[1:0];
                st_mask  = 4'b1111;
            end
            default: data_mis = 1'b1;
        endcase
    end

    assign ld_shift = mem_rdata >> {lat_off, 3'b000};

    always_comb begin
        case (lat_size)
            SZ_B:    ld_data = {{24{ld_shift[7] & ~lat_uns}}, ld_shift[7:0]};
            SZ_H:    ld_data = {{16{ld_shift[15] & ~lat_uns}}, ld_shift[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_nx         = state;
        own_if_nx        = own_if;
        prio_data_nx     = prio_data;
        lat_size_nx      = lat_size;
        lat_off_nx       = lat_off;
        lat_uns_nx       = lat_uns;
        mem_req_nx       = mem_req;
        mem_we_nx        = mem_we;
        mem_addr_nx      = mem_addr;
        mem_wdata_nx     = mem_wdata;
        mem_wmask_nx     = mem_wmask;
        if_done_nx       = 1'b0;
        data_done_nx     = 1'b0;
        data_misalign_nx = 1'b0;
        if_rdata_nx      = if_rdata;
        data_rdata_nx    = data_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        bus_err_nx       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (gnt_if) begin
                    prio_data_nx = 1'b1;
                    own_if_nx    = 1'b1;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = 1'b0;
                    mem_addr_nx  = {if_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_nx = '0;
                    mem_wmask_nx = '0;
                    state_nx     = BUSY;
                end else if (gnt_data) begin
                    prio_data_nx = 1'b0;
                    own_if_nx    = 1'b0;
                    if (data_mis) begin
                        // rejected without touching the bus
                        data_done_nx     = 1'b1;
                        data_misalign_nx = 1'b1;
                        data_rdata_nx    = '0;
                        state_nx         = DONE;
                    end else begin
                        lat_size_nx  = data_size;
                        lat_off_nx   = data_addr[1:0];
                        lat_uns_nx   = data_unsigned;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = data_we;
                        mem_addr_nx  = {data_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_nx = data_we ? st_wdata : 32'd0;
                        mem_wmask_nx = data_we ? st_mask : 4'd0;
                        state_nx     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_nx   = 1'b0;
                    mem_we_nx    = 1'b0;
                    mem_wmask_nx = '0;
                    state_nx     = DONE;
                    if (own_if) begin
                        if_done_nx  = 1'b1;
                        if_rdata_nx = mem_rdata;
                    end else begin
                        data_done_nx  = 1'b1;
                        data_rdata_nx = mem_we ? 32'd0 : ld_data;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    mem_req_nx   = 1'b0;
                    mem_we_nx    = 1'b0;
                    mem_wmask_nx = '0;
                    bus_err_nx   = 1'b1;
                    state_nx     = DONE;
                    if (own_if) begin
                        if_done_nx  = 1'b1;
                        if_rdata_nx = '0;
                    end else begin
                        data_done_nx  = 1'b1;
                        data_rdata_nx = '0;
                    end
                end
`endif
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_if        <= 1'b0;
            prio_data     <= 1'b1;
            lat_size      <= '0;
            lat_off       <= '0;
            lat_uns       <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            if_done       <= 1'b0;
            if_rdata      <= '0;
            data_done     <= 1'b0;
            data_rdata    <= '0;
            data_misalign <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err       <= 1'b0;
`endif
        end else begin
            own_if        <= own_if_nx;
            prio_data     <= prio_data_nx;
            lat_size      <= lat_size_nx;
            lat_off       <= lat_off_nx;
            lat_uns       <= lat_uns_nx;
            mem_req       <= mem_req_nx;
            mem_we        <= mem_we_nx;
            mem_addr      <= mem_addr_nx;
            mem_wdata     <= mem_wdata_nx;
            mem_wmask     <= mem_wmask_nx;
            if_done       <= if_done_nx;
            if_rdata      <= if_rdata_nx;
            data_done     <= data_done_nx;
            data_rdata    <= data_rdata_nx;
            data_misalign <= data_misalign_nx;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err       <= bus_err_nx;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: stimulus queues expectations, monitors check them.
module tb_mem_arbiter_ctrl;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, data_req, data_we, data_unsigned;
    logic [31:0] if_addr, data_addr, data_wdata;
    logic [1:0]  data_size;
    logic        if_done, data_done, data_misalign, stall_if, stall_mem;
    logic [31:0] if_rdata, data_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        bus_err;
`endif

    logic        rsp_en, auto_ack, man_ack;
    logic [31:0] auto_rdata, man_rdata;
    int          ack_dly;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        is_if;
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } bus_t;

    done_t       exp_done[$];
    bus_t        exp_bus[$];
    logic [31:0] rsp_q[$];

    assign mem_ack   = rsp_en ? auto_ack : man_ack;
    assign mem_rdata = rsp_en ? auto_rdata : man_rdata;

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_size(data_size),
        .data_unsigned(data_unsigned), .data_wdata(data_wdata), .data_done(data_done),
        .data_rdata(data_rdata), .data_misalign(data_misalign),
`ifdef MEM_ARB_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory model: acks the ack_dly-th cycle of each bus request
    initial begin : responder
        int cnt;
        cnt = 0;
        auto_ack = 1'b0;
        auto_rdata = '0;
        forever begin
            @(posedge clk); #1;
            auto_ack = 1'b0;
            if (rsp_en && mem_req) begin
                cnt++;
                if (cnt >= ack_dly) begin
                    auto_ack = 1'b1;
                    cnt = 0;
                    if (rsp_q.size() > 0) auto_rdata = rsp_q.pop_front();
                    else                  auto_rdata = 32'hBAD0BAD0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    logic req_q = 1'b0;
    always @(negedge clk) begin : monitor
        bus_t  b;
        done_t d;
        if (mem_req && !req_q) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: got request to %h expected no request", mem_addr);
            end else begin
                b = exp_bus.pop_front();
                chk("mem_addr", mem_addr, b.addr);
                chk("mem_we", mem_we, b.we);
                chk("mem_wmask", mem_wmask, b.mask);
                if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
            end
        end
        req_q <= mem_req;
        if (if_done || data_done) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got if_done=%0b data_done=%0b expected none", if_done, data_done);
            end else begin
                d = exp_done.pop_front();
                chk("if_done", if_done, d.is_if);
                chk("data_done", data_done, !d.is_if);
                if (d.is_if) begin
                    chk("if_rdata", if_rdata, d.rdata);
                end else begin
                    chk("data_rdata", data_rdata, d.rdata);
                    chk("data_misalign", data_misalign, d.mis);
                end
`ifdef MEM_ARB_TIMEOUT_EN
                chk("bus_err", bus_err, d.berr);
`endif
            end
        end
    end

    task automatic wait_done(input logic is_if, input logic chk_stall, output int cyc);
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (is_if ? if_done : data_done) begin
                if (chk_stall) chk("stall_at_done", is_if ? stall_if : stall_mem, 1'b0);
                return;
            end
            if (chk_stall) chk("stall_waiting", is_if ? stall_if : stall_mem, 1'b1);
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after 50 cycles expected a done pulse");
    endtask

    task automatic push_done(input logic is_if, input logic [31:0] rd, input logic mis, input logic berr);
        done_t d;
        d.is_if = is_if; d.rdata = rd; d.mis = mis; d.berr = berr;
        exp_done.push_back(d);
    endtask

    task automatic push_bus(input logic [31:0] addr, input logic we, input logic [3:0] mask,
                            input logic [31:0] wd);
        bus_t b;
        b.addr = addr; b.we = we; b.mask = mask; b.wdata = wd;
        exp_bus.push_back(b);
    endtask

    task automatic data_op(input string nm, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wd,
                           input logic [31:0] bus_rd, input logic mis, input logic [31:0] exp_rd,
                           input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                           input logic berr, input int exp_lat);
        int cyc;
        if (!mis) begin
            push_bus(addr & 32'hFFFF_FFFC, we, exp_mask, exp_wd);
            if (rsp_en) rsp_q.push_back(bus_rd);
        end
        push_done(1'b0, exp_rd, mis, berr);
        @(posedge clk); #1;
        data_req = 1'b1; data_we = we; data_addr = addr; data_size = size;
        data_unsigned = uns; data_wdata = wd;
        wait_done(1'b0, 1'b1, cyc);
        chk({nm, "_latency"}, cyc, exp_lat);
        data_req = 1'b0; data_we = 1'b0; data_wdata = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        rst = 1'b1; rsp_en = 1'b1; ack_dly = 1; man_ack = 1'b0; man_rdata = '0;
        if_req = 1'b0; if_addr = '0; data_req = 1'b0; data_we = 1'b0; data_addr = '0;
        data_size = 2'd2; data_unsigned = 1'b0; data_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", mem_wmask, 4'h0);
        chk("rst_if_done", if_done, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_data_done", data_done, 1'b0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        chk("rst_data_misalign", data_misalign, 1'b0);

        // both requesters from reset: data, fetch, data, fetch
        push_bus(32'h300, 1'b0, 4'h0, 32'h0); push_bus(32'h40, 1'b0, 4'h0, 32'h0);
        push_bus(32'h304, 1'b0, 4'h0, 32'h0); push_bus(32'h44, 1'b0, 4'h0, 32'h0);
        rsp_q.push_back(32'h1111_1111); rsp_q.push_back(32'h2222_2222);
        rsp_q.push_back(32'h3333_3333); rsp_q.push_back(32'h4444_4444);
        push_done(1'b0, 32'h1111_1111, 1'b0, 1'b0); push_done(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        push_done(1'b0, 32'h3333_3333, 1'b0, 1'b0); push_done(1'b1, 32'h4444_4444, 1'b0, 1'b0);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        data_req = 1'b1; data_addr = 32'h300; data_size = 2'd2;
        wait_done(1'b0, 1'b0, cyc);
        chk("alt_stall_if_held", stall_if, 1'b1);
        data_req = 1'b0;
        @(posedge clk); #1;
        data_req = 1'b1; data_addr = 32'h304;
        wait_done(1'b1, 1'b1, cyc);
        chk("alt_stall_mem_held", stall_mem, 1'b1);
        if_req = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h44;
        wait_done(1'b0, 1'b0, cyc);
        chk("alt2_stall_if_held", stall_if, 1'b1);
        data_req = 1'b0;
        wait_done(1'b1, 1'b0, cyc);
        if_req = 1'b0;

        // loads
        ack_dly = 2;
        data_op("lw",   0, 32'h100, 2'd2, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'h0, 0, 0, 3);
        ack_dly = 1;
        data_op("lb",   0, 32'h103, 2'd0, 0, 0, 32'h80FF1234, 0, 32'hFFFFFF80, 4'h0, 0, 0, 2);
        data_op("lbu",  0, 32'h103, 2'd0, 1, 0, 32'h80FF1234, 0, 32'h00000080, 4'h0, 0, 0, 2);
        data_op("lhu",  0, 32'h102, 2'd1, 1, 0, 32'h80FF1234, 0, 32'h000080FF, 4'h0, 0, 0, 2);
        data_op("lh",   0, 32'h102, 2'd1, 0, 0, 32'h80FF1234, 0, 32'hFFFF80FF, 4'h0, 0, 0, 2);
        data_op("lh_lo",0, 32'h100, 2'd1, 0, 0, 32'h80FF1234, 0, 32'h00001234, 4'h0, 0, 0, 2);
        data_op("lb1",  0, 32'h101, 2'd0, 0, 0, 32'h80FF1234, 0, 32'h00000012, 4'h0, 0, 0, 2);
        // stores
        ack_dly = 3;
        data_op("sh",   1, 32'h202, 2'd1, 0, 32'h0000ABCD, 32'h55555555, 0, 0, 4'b1100, 32'hABCDABCD, 0, 4);
        ack_dly = 1;
        data_op("sb",   1, 32'h201, 2'd0, 0, 32'h000000EE, 32'h55555555, 0, 0, 4'b0010, 32'hEEEEEEEE, 0, 2);
        data_op("sw",   1, 32'h204, 2'd2, 0, 32'h12345678, 32'h55555555, 0, 0, 4'b1111, 32'h12345678, 0, 2);
        // misaligned: no bus cycle, done the next cycle
        data_op("lw_mis", 0, 32'h101, 2'd2, 0, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        data_op("lh_mis", 0, 32'h103, 2'd1, 0, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        data_op("sz3",    0, 32'h100, 2'd3, 0, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        data_op("sh_mis", 1, 32'h201, 2'd1, 0, 32'hFFFF, 0, 1, 0, 4'h0, 0, 0, 1);

        // reset in the middle of a bus cycle, then a stray ack
        rsp_en = 1'b0;
        push_bus(32'h400, 1'b0, 4'h0, 32'h0);
        @(posedge clk); #1;
        data_req = 1'b1; data_addr = 32'h400; data_size = 2'd2; data_we = 1'b0;
        @(posedge clk); #1;
        chk("busy_mem_req", mem_req, 1'b1);
        rst = 1'b1; data_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; man_ack = 1'b1; man_rdata = 32'hFFFF_FFFF;
        chk("mid_rst_mem_req", mem_req, 1'b0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        chk("mid_rst_data_rdata", data_rdata, 32'h0);
        chk("mid_rst_if_rdata", if_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        man_ack = 1'b0;
        chk("stray_ack_mem_req", mem_req, 1'b0);
        chk("stray_ack_data_done", data_done, 1'b0);
        chk("stray_ack_data_rdata", data_rdata, 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
        data_op("tmo", 0, 32'h500, 2'd2, 0, 0, 0, 0, 0, 4'h0, 0, 1, 5);
`endif
        rsp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_queue_empty", exp_done.size(), 0);
        chk("bus_queue_empty", exp_bus.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
